// File: rtl/reg_alu_seq.sv
// Purpose: command-driven sequencer that drives one reg_alu (register file + ALU)
//          through LOAD / ALU / READ / CLEAR control cycles and returns results.
// Latency: accept edge to rsp_valid is LOAD/ALU 3, READ 2, CLEAR NREG+1 cycles.
// Backpressure: a single command is outstanding at a time. cmd_ready is high only in IDLE.
//               RESP holds the response stable until rsp_ready, with no time limit.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_*      : command port (valid/ready), fields captured at the accept edge
//   rsp_*      : response port (valid/ready), rsp_a/rsp_b data, rsp_cout ALU carry
//   sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in : controls to reg_alu
//   d_out_a, d_out_b, cout                          : combinational results from reg_alu
module reg_alu_seq #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_type,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic          rsp_cout,
  output logic          sel,
  output logic          wr,
  output logic [1:0]    op,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] d_in,
  input  logic [DW-1:0] d_out_a,
  input  logic [DW-1:0] d_out_b,
  input  logic          cout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RDBK,
    S_CLR,
    S_RESP
  } state_t;

  localparam logic [1:0] T_LOAD  = 2'b00;
  localparam logic [1:0] T_ALU   = 2'b01;
  localparam logic [1:0] T_READ  = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] srca_q, srca_d;
  logic [AW-1:0] srcb_q, srcb_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rsp_a_q, rsp_a_d;
  logic [DW-1:0] rsp_b_q, rsp_b_d;
  logic          rsp_cout_q, rsp_cout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      imm_q      <= '0;
      cnt_q      <= '0;
      rsp_a_q    <= '0;
      rsp_b_q    <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
      rsp_a_q    <= rsp_a_d;
      rsp_b_q    <= rsp_b_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  // Next-state and response capture.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    op_d       = op_q;
    dst_d      = dst_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    imm_d      = imm_q;
    cnt_d      = cnt_q;
    rsp_a_d    = rsp_a_q;
    rsp_b_d    = rsp_b_q;
    rsp_cout_d = rsp_cout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          type_d     = cmd_type;
          op_d       = cmd_op;
          dst_d      = cmd_dst;
          srca_d     = cmd_srca;
          srcb_d     = cmd_srcb;
          imm_d      = cmd_imm;
          cnt_d      = '0;
          // Start every command from a zero response so fields a command
          // does not produce (e.g. cout for LOAD) read back as 0.
          rsp_a_d    = '0;
          rsp_b_d    = '0;
          rsp_cout_d = 1'b0;
          state_d    = (cmd_type == T_CLEAR) ? S_CLR : S_EXEC;
        end
      end
      S_EXEC: begin
        if (type_q == T_ALU) begin
          rsp_cout_d = cout;
        end
        if (type_q == T_READ) begin
          rsp_a_d = d_out_a;
          rsp_b_d = d_out_b;
          state_d = S_RESP;
        end else begin
          state_d = S_RDBK;
        end
      end
      S_RDBK: begin
        // The EXEC write has landed, so reading dst returns the new value
        // even when dst aliases a source.
        rsp_a_d = d_out_a;
        rsp_b_d = '0;
        state_d = S_RESP;
      end
      S_CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // reg_alu control outputs, derived from state and captured command.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    wr        = 1'b0;
    sel       = 1'b0;
    op        = (type_q == T_ALU) ? op_q : 2'b00;
    rd_addr_a = (state_q == S_RDBK) ? dst_q : srca_q;
    rd_addr_b = srcb_q;
    wr_addr   = (state_q == S_CLR) ? cnt_q : dst_q;
    d_in      = (state_q == S_CLR) ? '0 : imm_q;
    if (state_q == S_EXEC) begin
      wr  = (type_q == T_LOAD) || (type_q == T_ALU);
      sel = (type_q == T_ALU);
    end
    if (state_q == S_CLR) begin
      wr = 1'b1;
    end
  end

  assign rsp_a    = rsp_a_q;
  assign rsp_b    = rsp_b_q;
  assign rsp_cout = rsp_cout_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
module tb_reg_alu_seq;

  localparam logic [1:0] T_LOAD  = 2'b00;
  localparam logic [1:0] T_ALU   = 2'b01;
  localparam logic [1:0] T_READ  = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type, cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic [15:0] cmd_imm;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_a, rsp_b;
  logic        rsp_cout;
  logic        sel, wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, d_out_a, d_out_b;
  logic        cout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  reg_alu_seq #(.NREG(8), .AW(3), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .rsp_cout(rsp_cout), .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in), .d_out_a(d_out_a),
    .d_out_b(d_out_b), .cout(cout)
  );

  // ALU: 00 add, 01 subtract (carry = no borrow), 10 and, 11 xor.
  function automatic logic [16:0] alu17(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} + {1'b0, ~b} + 17'd1;
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Stand-in for the reg_alu instance: 8x16 file, combinational reads.
  logic [15:0] rf [8];
  logic [16:0] alu_res;
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];
  assign alu_res = alu17(op, d_out_a, d_out_b);
  assign cout    = alu_res[16];
  always @(posedge clk) if (wr) rf[wr_addr] <= sel ? alu_res[15:0] : d_in;

  // Write-cycle log for pulse/sweep checks.
  int wr_addr_log[$];
  int wr_cyc_log[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && wr) begin
      wr_addr_log.push_back(int'(wr_addr));
      wr_cyc_log.push_back(cyc);
    end
  end

  // Reference register contents as the host sees them.
  logic [15:0] exp_rf [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_cmd(input logic [1:0] t, input logic [1:0] f, input logic [2:0] dst,
                        input logic [2:0] a, input logic [2:0] b, input logic [15:0] imm,
                        input int hold, output int lat, output logic [15:0] ra,
                        output logic [15:0] rb, output logic rc);
    int w;
    cmd_type = t; cmd_op = f; cmd_dst = dst; cmd_srca = a; cmd_srcb = b; cmd_imm = imm;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scramble fields after accept; the DUT must use its captured copy.
    cmd_type = 2'($urandom); cmd_op = 2'($urandom); cmd_dst = 3'($urandom);
    cmd_srca = 3'($urandom); cmd_srcb = 3'($urandom); cmd_imm = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    ra = rsp_a; rb = rsp_b; rc = rsp_cout;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == hold / 2);
      cmd_type = T_LOAD; cmd_dst = 3'd0; cmd_imm = 16'h5A5A;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("hold_rsp_a", rsp_a, ra);
      chk("hold_rsp_b", rsp_b, rb);
      chk("hold_cout", rsp_cout, rc);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // Issue a command, predict its response from exp_rf, compare, update exp_rf.
  task automatic run(input string tag, input logic [1:0] t, input logic [1:0] f,
                     input logic [2:0] dst, input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] imm, input int hold);
    int lat, elat;
    logic [15:0] ra, rb, ea, eb;
    logic rc, ec;
    logic [16:0] r;
    ea = 0; eb = 0; ec = 0;
    case (t)
      T_LOAD:  begin ea = imm; exp_rf[dst] = imm; elat = 3; end
      T_ALU:   begin r = alu17(f, exp_rf[a], exp_rf[b]); ea = r[15:0]; ec = r[16];
                     exp_rf[dst] = r[15:0]; elat = 3; end
      T_READ:  begin ea = exp_rf[a]; eb = exp_rf[b]; elat = 2; end
      default: begin for (int i = 0; i < 8; i++) exp_rf[i] = 0; elat = 9; end
    endcase
    do_cmd(t, f, dst, a, b, imm, hold, lat, ra, rb, rc);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_rsp_a"}, ra, ea);
    chk({tag, "_rsp_b"}, rb, eb);
    chk({tag, "_cout"}, rc, ec);
  endtask

  initial begin
    int w;
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_type = 0; cmd_op = 0; cmd_dst = 0; cmd_srca = 0; cmd_srcb = 0; cmd_imm = 0;
    for (int i = 0; i < 8; i++) begin rf[i] = 0; exp_rf[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {rsp_valid, wr, sel, op, rd_addr_a, rd_addr_b, wr_addr}, 0);
    chk("rst_d_in", d_in, 0);
    chk("rst_rsp", {rsp_a, rsp_b, rsp_cout}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // LOAD: single write pulse to r3, data read back.
    wr_addr_log.delete(); wr_cyc_log.delete();
    run("t1_load", T_LOAD, 2'b00, 3'd3, 3'd0, 3'd0, 16'hBEEF, 0);
    chk("t1_wr_count", wr_addr_log.size(), 1);
    chk("t1_wr_addr", wr_addr_log.size() > 0 ? wr_addr_log[0] : 99, 3);

    // Add with carry out, then read back both operands' destinations.
    run("t2_ld1", T_LOAD, 2'b00, 3'd1, 3'd0, 3'd0, 16'hFFFF, 0);
    run("t2_ld2", T_LOAD, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
    run("t2_add", T_ALU, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
    run("t2_read", T_READ, 2'b00, 3'd0, 3'd4, 3'd1, 16'h0000, 0);

    // In-place ALU: operands read before the write lands.
    run("t3_ld", T_LOAD, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0003, 0);
    run("t3_alu", T_ALU, 2'b00, 3'd1, 3'd1, 3'd1, 16'h0000, 0);
    chk("t3_r1_six", exp_rf[1], 16'h0006);

    // CLEAR sweep after filling every register.
    for (int i = 0; i < 8; i++)
      run("t4_fill", T_LOAD, 2'b00, 3'(i), 3'd0, 3'd0, 16'($urandom_range(1, 65535)), 0);
    wr_addr_log.delete(); wr_cyc_log.delete();
    run("t4_clear", T_CLEAR, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 0);
    chk("t4_wr_count", wr_addr_log.size(), 8);
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      chk("t4_wr_addr", wr_addr_log[i], i);
      chk("t4_wr_consec", wr_cyc_log[i] - wr_cyc_log[0], i);
    end
    for (int i = 0; i < 8; i += 2)
      run("t4_read", T_READ, 2'b00, 3'd0, 3'(i), 3'(i + 1), 16'h0000, 0);

    // Long backpressure with a stray command pulse.
    run("t5_ld", T_LOAD, 2'b00, 3'd6, 3'd0, 3'd0, 16'h1234, 0);
    run("t5_hold", T_READ, 2'b00, 3'd0, 3'd6, 3'd3, 16'h0000, 10);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] t;
      t = ($urandom_range(0, 19) == 0) ? T_CLEAR : 2'($urandom_range(0, 2));
      run("rnd", t, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
          16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a CLEAR sweep.
    for (int i = 0; i < 8; i++)
      run("t6_fill", T_LOAD, 2'b00, 3'(i), 3'd0, 3'd0, 16'($urandom_range(1, 65535)), 0);
    cmd_type = T_CLEAR; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w = 0;
    while (!(wr && wr_addr == 3'd3) && w < 20) begin @(posedge clk); #1; w++; end
    chk("t6_reach_cnt3", {wr, wr_addr}, {1'b1, 3'd3});
    reset = 1'b0;
    #1;
    chk("t6_rst_outs", {rsp_valid, wr, sel, op, rd_addr_a, rd_addr_b, wr_addr}, 0);
    chk("t6_rst_d_in", d_in, 0);
    chk("t6_rst_rsp", {rsp_a, rsp_b, rsp_cout}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) exp_rf[i] = 0;
    run("t6_rd01", T_READ, 2'b00, 3'd0, 3'd0, 3'd1, 16'h0000, 0);
    run("t6_rd24", T_READ, 2'b00, 3'd0, 3'd2, 3'd4, 16'h0000, 0);
    run("t6_rd56", T_READ, 2'b00, 3'd0, 3'd5, 3'd6, 16'h0000, 0);
    run("t6_rd77", T_READ, 2'b00, 3'd0, 3'd7, 3'd7, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
